// File: rtl/uart_pkg.sv
// Shared UART definitions (used by uart_tx and uart_rx): FSM encoding and default frame timing.
// Build option: UART_TX_PARITY_EN widens the state encoding to make room for the PARITY state.
package uart_pkg;

  localparam int unsigned NB_DATA_DEF = 8;
  localparam int unsigned S_TICK_DEF  = 651;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned ST_W = 3;
`else
  localparam int unsigned ST_W = 2;
`endif

  localparam logic [ST_W-1:0] IDLE   = ST_W'(0);
  localparam logic [ST_W-1:0] START  = ST_W'(1);
  localparam logic [ST_W-1:0] DATA   = ST_W'(2);
  localparam logic [ST_W-1:0] STOP   = ST_W'(3);
`ifdef UART_TX_PARITY_EN
  localparam logic [ST_W-1:0] PARITY = ST_W'(4);
`endif

endpackage

// File: rtl/uart_tx_if.sv
// Host-side bundle of the UART transmitter: baud tick, request/payload and line/status outputs.
// Build option: none (UART_TX_PARITY_EN only affects uart_tx internals).
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF
);

  logic               s_tick;
  logic               tx_start;
  logic [NB_DATA-1:0] data_in;
  logic               tx;
  logic               tx_busy;
  logic               tx_done_tick;

  modport master (
    output s_tick,
    output tx_start,
    output data_in,
    input  tx,
    input  tx_busy,
    input  tx_done_tick
  );

  modport slave (
    input  s_tick,
    input  tx_start,
    input  data_in,
    output tx,
    output tx_busy,
    output tx_done_tick
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, stop bit, paced by an external s_tick.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned S_TICK  = S_TICK_DEF
) (
  input  logic    clk,
  input  logic    reset,
  uart_tx_if.slave bus
);

  localparam int unsigned TW = $clog2(S_TICK);
  localparam int unsigned BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  logic [ST_W-1:0]    state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tick_end;
`ifdef UART_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  assign tick_end = bus.s_tick && (tick_q == TW'(S_TICK - 1));

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Ticks only advance the counter outside IDLE; a tick on the accepting cycle is dropped.
    if (state_q != IDLE && bus.s_tick) begin
      tick_d = tick_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          state_d = START;
          shreg_d = bus.data_in;
          tick_d  = '0;
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^bus.data_in;
`endif
        end
      end
      START: begin
        if (tick_end) state_d = DATA;
      end
      DATA: begin
        if (tick_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BW'(NB_DATA - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    // Line level follows the current state, so the line trails the FSM by one clock.
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_done_tick = done_q;

endmodule
